// File: rtl/arcade_input_mux.sv
// Player-input front end: merges PS/2 key state with MiSTer joysticks, adds
// autofire and coin-pulse stretching, and holds the HPS-loaded DIP banks.
module arcade_input_mux #(
   parameter int         PLAYERS      = 2,
   parameter int         BUTTONS      = 4,
   parameter int         COIN_PULSE   = 2400000,
   parameter int         AUTOFIRE_DIV = 400000,
   parameter int         DIP_BANKS    = 8,
   parameter logic [7:0] DIP_INIT     = 8'h00
) (
   input  logic                         clk_sys,
   input  logic                         reset_n,
   input  logic [10:0]                  ps2_key,
   input  logic [16*PLAYERS-1:0]        joy_in,
   input  logic [BUTTONS-1:0]           autofire_mask,
   input  logic                         ioctl_wr,
   input  logic [7:0]                   ioctl_index,
   input  logic [24:0]                  ioctl_addr,
   input  logic [7:0]                   ioctl_dout,
   output logic [4*PLAYERS-1:0]         dir,
   output logic [BUTTONS*PLAYERS-1:0]   btn,
   output logic [PLAYERS-1:0]           start,
   output logic [PLAYERS-1:0]           coin,
   output logic [8*DIP_BANKS-1:0]       dip
);

   localparam int CW = $clog2(COIN_PULSE);
   localparam int AW = (AUTOFIRE_DIV > 1) ? $clog2(AUTOFIRE_DIV) : 1;
   localparam int NB = BUTTONS * PLAYERS;

   typedef enum logic [2:0] {K_NONE, K_DIR, K_BTN, K_START, K_COIN} key_kind_e;
   typedef enum logic {C_IDLE, C_PULSE} coin_st_e;

   key_kind_e kind;
   logic [1:0] kp;
   logic [2:0] ki;

   logic tog_q, first_q, kb_evt;
   logic [4*PLAYERS-1:0] kb_dir_q, kb_dir_d, dir_raw, dir_q;
   logic [NB-1:0] kb_btn_q, kb_btn_d, btn_raw, btn_af, btn_q;
   logic [PLAYERS-1:0] kb_start_q, kb_start_d, start_raw, start_q;
   logic [PLAYERS-1:0] kb_coin_q, kb_coin_d, coin_raw, coin_raw_q, coin_prev_q, coin_rise;
   logic [AW-1:0] af_cnt_q;
   logic af_phase_q;

   // Scan-code map: kind/player/index for the current ps2_key code
   always_comb begin
      kind = K_NONE;
      kp   = 2'd0;
      ki   = 3'd0;
      if (ps2_key[8]) begin
         case (ps2_key[7:0])
            8'h75: begin kind = K_DIR; ki = 3'd3; end
            8'h72: begin kind = K_DIR; ki = 3'd2; end
            8'h6B: begin kind = K_DIR; ki = 3'd1; end
            8'h74: begin kind = K_DIR; ki = 3'd0; end
            default: ;
         endcase
      end else begin
         case (ps2_key[7:0])
            8'h14: begin kind = K_BTN; ki = 3'd0; end
            8'h11: begin kind = K_BTN; ki = 3'd1; end
            8'h29: begin kind = K_BTN; ki = 3'd2; end
            8'h12: begin kind = K_BTN; ki = 3'd3; end
            8'h1A: begin kind = K_BTN; ki = 3'd4; end
            8'h22: begin kind = K_BTN; ki = 3'd5; end
            8'h21: begin kind = K_BTN; ki = 3'd6; end
            8'h2A: begin kind = K_BTN; ki = 3'd7; end
            8'h2D: begin kind = K_DIR; kp = 2'd1; ki = 3'd3; end
            8'h2B: begin kind = K_DIR; kp = 2'd1; ki = 3'd2; end
            8'h23: begin kind = K_DIR; kp = 2'd1; ki = 3'd1; end
            8'h34: begin kind = K_DIR; kp = 2'd1; ki = 3'd0; end
            8'h1C: begin kind = K_BTN; kp = 2'd1; ki = 3'd0; end
            8'h1B: begin kind = K_BTN; kp = 2'd1; ki = 3'd1; end
            8'h15: begin kind = K_BTN; kp = 2'd1; ki = 3'd2; end
            8'h1D: begin kind = K_BTN; kp = 2'd1; ki = 3'd3; end
            8'h43: begin kind = K_BTN; kp = 2'd1; ki = 3'd4; end
            8'h42: begin kind = K_BTN; kp = 2'd1; ki = 3'd5; end
            8'h3B: begin kind = K_BTN; kp = 2'd1; ki = 3'd6; end
            8'h4B: begin kind = K_BTN; kp = 2'd1; ki = 3'd7; end
            8'h16, 8'h05: begin kind = K_START; kp = 2'd0; end
            8'h1E, 8'h06: begin kind = K_START; kp = 2'd1; end
            8'h26: begin kind = K_START; kp = 2'd2; end
            8'h25: begin kind = K_START; kp = 2'd3; end
            8'h2E, 8'h76: begin kind = K_COIN; kp = 2'd0; end
            8'h36: begin kind = K_COIN; kp = 2'd1; end
            8'h3D: begin kind = K_COIN; kp = 2'd2; end
            8'h3E: begin kind = K_COIN; kp = 2'd3; end
            default: ;
         endcase
      end
   end

   // first_q suppresses a false event when the toggle is already high at reset
   assign kb_evt = !first_q && (ps2_key[10] != tog_q);

   always_comb begin
      kb_dir_d   = kb_dir_q;
      kb_btn_d   = kb_btn_q;
      kb_start_d = kb_start_q;
      kb_coin_d  = kb_coin_q;
      if (kb_evt) begin
         for (int i = 0; i < 4*PLAYERS; i++)
            if (kind == K_DIR && i == 4*int'(kp) + int'(ki)) kb_dir_d[i] = ps2_key[9];
         for (int i = 0; i < NB; i++)
            if (kind == K_BTN && int'(ki) < BUTTONS && i == BUTTONS*int'(kp) + int'(ki))
               kb_btn_d[i] = ps2_key[9];
         for (int i = 0; i < PLAYERS; i++) begin
            if (kind == K_START && i == int'(kp)) kb_start_d[i] = ps2_key[9];
            if (kind == K_COIN && i == int'(kp)) kb_coin_d[i] = ps2_key[9];
         end
      end
   end

   assign btn_af = btn_raw & (~{PLAYERS{autofire_mask}} | {NB{af_phase_q}});
   assign coin_rise = coin_raw_q & ~coin_prev_q;

   // Raw registers start high so a coin held through reset cannot fire
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         tog_q       <= 1'b0;
         first_q     <= 1'b1;
         kb_dir_q    <= '0;
         kb_btn_q    <= '0;
         kb_start_q  <= '0;
         kb_coin_q   <= '0;
         dir_q       <= '0;
         btn_q       <= '0;
         start_q     <= '0;
         coin_raw_q  <= '1;
         coin_prev_q <= '1;
         af_cnt_q    <= '0;
         af_phase_q  <= 1'b1;
      end else begin
         tog_q       <= ps2_key[10];
         first_q     <= 1'b0;
         kb_dir_q    <= kb_dir_d;
         kb_btn_q    <= kb_btn_d;
         kb_start_q  <= kb_start_d;
         kb_coin_q   <= kb_coin_d;
         dir_q       <= dir_raw;
         btn_q       <= btn_af;
         start_q     <= start_raw;
         coin_raw_q  <= coin_raw;
         coin_prev_q <= coin_raw_q;
         if (af_cnt_q == AW'(AUTOFIRE_DIV - 1)) begin
            af_cnt_q   <= '0;
            af_phase_q <= ~af_phase_q;
         end else begin
            af_cnt_q <= af_cnt_q + AW'(1);
         end
      end
   end

   assign dir   = dir_q;
   assign btn   = btn_q;
   assign start = start_q;

   for (genvar p = 0; p < PLAYERS; p++) begin : g_player
      coin_st_e st_q, st_d;
      logic [CW-1:0] cnt_q, cnt_d;
      logic unused_joy;

      assign unused_joy = ^joy_in[16*p+15 : 16*p+6+BUTTONS];
      assign dir_raw[4*p +: 4] = kb_dir_q[4*p +: 4] | joy_in[16*p +: 4];
      assign btn_raw[BUTTONS*p +: BUTTONS] = kb_btn_q[BUTTONS*p +: BUTTONS]
                                           | joy_in[16*p+4 +: BUTTONS];
      assign start_raw[p] = kb_start_q[p] | joy_in[16*p+4+BUTTONS];
      assign coin_raw[p]  = kb_coin_q[p]  | joy_in[16*p+5+BUTTONS];

      always_ff @(posedge clk_sys or negedge reset_n) begin
         if (!reset_n) begin
            st_q  <= C_IDLE;
            cnt_q <= '0;
         end else begin
            st_q  <= st_d;
            cnt_q <= cnt_d;
         end
      end

      // Edges seen while pulsing, terminal cycle included, are discarded
      always_comb begin
         st_d  = st_q;
         cnt_d = cnt_q;
         case (st_q)
            C_IDLE: if (coin_rise[p]) begin
               st_d  = C_PULSE;
               cnt_d = '0;
            end
            C_PULSE: begin
               if (cnt_q == CW'(COIN_PULSE - 1)) st_d = C_IDLE;
               else cnt_d = cnt_q + CW'(1);
            end
            default: st_d = C_IDLE;
         endcase
      end

      assign coin[p] = (st_q == C_PULSE);
   end

   for (genvar b = 0; b < DIP_BANKS; b++) begin : g_dip
      logic [7:0] bank_q;

      always_ff @(posedge clk_sys or negedge reset_n) begin
         if (!reset_n) begin
            bank_q <= DIP_INIT;
         end else if (ioctl_wr && ioctl_index == 8'd254 && ioctl_addr[24:3] == '0
                      && ioctl_addr[2:0] == 3'(b)) begin
            bank_q <= ioctl_dout;
         end
      end

      assign dip[8*b +: 8] = bank_q;
   end

endmodule

// File: tb/tb_arcade_input_mux.sv
// Directed bench for arcade_input_mux: a two-player build and a reduced
// one-player/two-button/two-bank build share the keyboard and HPS inputs.
module tb_arcade_input_mux;

   logic        clk_sys = 1'b0;
   logic        reset_n;
   logic [10:0] ps2_key;
   logic        ioctl_wr;
   logic [7:0]  ioctl_index;
   logic [24:0] ioctl_addr;
   logic [7:0]  ioctl_dout;

   logic [31:0] joy_a;
   logic [3:0]  af_a;
   logic [7:0]  dir_a, btn_a;
   logic [1:0]  start_a, coin_a;
   logic [63:0] dip_a;

   logic [15:0] joy_b;
   logic [1:0]  af_b;
   logic [3:0]  dir_b;
   logic [1:0]  btn_b;
   logic [0:0]  start_b, coin_b;
   logic [15:0] dip_b;

   int   n_chk = 0;
   int   n_err = 0;
   int   cyc = 0;
   logic tog;

   always #5 clk_sys = ~clk_sys;

   arcade_input_mux #(.PLAYERS(2), .BUTTONS(4), .COIN_PULSE(8), .AUTOFIRE_DIV(4),
                      .DIP_BANKS(8), .DIP_INIT(8'h3C)) dut_a (
      .clk_sys(clk_sys), .reset_n(reset_n), .ps2_key(ps2_key), .joy_in(joy_a),
      .autofire_mask(af_a), .ioctl_wr(ioctl_wr), .ioctl_index(ioctl_index),
      .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .dir(dir_a), .btn(btn_a),
      .start(start_a), .coin(coin_a), .dip(dip_a));

   arcade_input_mux #(.PLAYERS(1), .BUTTONS(2), .COIN_PULSE(8), .AUTOFIRE_DIV(4),
                      .DIP_BANKS(2), .DIP_INIT(8'h00)) dut_b (
      .clk_sys(clk_sys), .reset_n(reset_n), .ps2_key(ps2_key), .joy_in(joy_b),
      .autofire_mask(af_b), .ioctl_wr(ioctl_wr), .ioctl_index(ioctl_index),
      .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .dir(dir_b), .btn(btn_b),
      .start(start_b), .coin(coin_b), .dip(dip_b));

   // Edges since reset release; the autofire phase is derived from this
   always @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) cyc <= 0;
      else          cyc <= cyc + 1;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk_sys);
   endtask

   task automatic key(input logic ext, input logic pressed, input logic [7:0] code);
      tog = ~tog;
      ps2_key = {tog, pressed, ext, code};
   endtask

   task automatic dipw(input logic [7:0] idx, input logic [24:0] addr, input logic [7:0] d);
      ioctl_wr = 1'b1; ioctl_index = idx; ioctl_addr = addr; ioctl_dout = d;
      step(1);
      ioctl_wr = 1'b0;
   endtask

   initial begin
      reset_n = 1'b0;
      tog = 1'b1;
      ps2_key = {1'b1, 1'b1, 1'b1, 8'h75};
      joy_a = '0; joy_b = '0; af_a = '0; af_b = '0;
      ioctl_wr = 1'b0; ioctl_index = '0; ioctl_addr = '0; ioctl_dout = '0;
      step(2);
      reset_n = 1'b1;
      step(10);
      chk("rst_dir_a", dir_a, 8'h00);
      chk("rst_btn_a", btn_a, 8'h00);
      chk("rst_start_a", start_a, 2'b00);
      chk("rst_coin_a", coin_a, 2'b00);
      chk("rst_dip_a", dip_a, {8{8'h3C}});
      chk("rst_dip_b", dip_b, 16'h0000);
      chk("rst_dir_b", dir_b, 4'h0);

      key(1'b1, 1'b1, 8'h75);
      step(1); chk("up_press_e1", dir_a, 8'h00);
      step(1); chk("up_press_e2", dir_a, 8'h08);
      chk("up_press_b", dir_b, 4'h8);
      key(1'b1, 1'b0, 8'h75);
      step(1); chk("up_rel_e1", dir_a, 8'h08);
      step(1); chk("up_rel_e2", dir_a, 8'h00);
      key(1'b0, 1'b1, 8'h75);
      step(3); chk("up_noext", dir_a, 8'h00);
      key(1'b0, 1'b0, 8'h75);
      step(2);

      key(1'b0, 1'b1, 8'h1C);
      step(1); chk("p2b0_e1", btn_a, 8'h00);
      key(1'b0, 1'b0, 8'h1C);
      step(1); chk("p2b0_press", btn_a, 8'h10);
      chk("p2b0_b_ignored", btn_b, 2'b00);
      step(1); chk("p2b0_release", btn_a, 8'h00);

      key(1'b0, 1'b1, 8'h2A);
      step(3); chk("p1b7_a", btn_a, 8'h00);
      chk("p1b7_b", btn_b, 2'b00);
      key(1'b0, 1'b0, 8'h2A);
      step(2);
      key(1'b0, 1'b1, 8'h11);
      step(2); chk("p1b1_a", btn_a, 8'h02);
      chk("p1b1_b", btn_b, 2'b10);
      key(1'b0, 1'b0, 8'h11);
      step(2); chk("p1b1_rel_b", btn_b, 2'b00);

      key(1'b1, 1'b1, 8'h74);
      joy_a[0] = 1'b1;
      step(2); chk("right_both", dir_a, 8'h01);
      key(1'b1, 1'b0, 8'h74);
      step(3); chk("right_joy_held", dir_a, 8'h01);
      joy_a[0] = 1'b0;
      step(1); chk("right_off", dir_a, 8'h00);

      key(1'b0, 1'b1, 8'h16);
      step(2); chk("start1_key", start_a, 2'b01);
      key(1'b0, 1'b0, 8'h16);
      step(2); chk("start1_rel", start_a, 2'b00);
      key(1'b0, 1'b1, 8'h06);
      step(2); chk("start2_alias", start_a, 2'b10);
      key(1'b0, 1'b0, 8'h06);
      step(2);
      joy_a[24] = 1'b1;
      step(1); chk("start2_joy", start_a, 2'b10);
      joy_a[24] = 1'b0;
      step(1); chk("start2_joy_off", start_a, 2'b00);
      step(3);

      joy_a[25] = 1'b1;
      for (int i = 1; i <= 20; i++) begin
         step(1);
         chk($sformatf("coin_hold_%0d", i), coin_a, (i >= 2 && i <= 9) ? 2'b10 : 2'b00);
      end
      joy_a[25] = 1'b0;
      step(4);

      joy_a[25] = 1'b1;
      for (int i = 1; i <= 14; i++) begin
         step(1);
         chk($sformatf("coin_repress_%0d", i), coin_a, (i >= 2 && i <= 9) ? 2'b10 : 2'b00);
         if (i == 3) joy_a[25] = 1'b0;
         if (i == 5) joy_a[25] = 1'b1;
         if (i == 7) joy_a[25] = 1'b0;
      end
      step(3);

      joy_a[25] = 1'b1;
      step(4); chk("coin_before_rst", coin_a, 2'b10);
      #1 reset_n = 1'b0;
      #1 chk("coin_async_rst", coin_a, 2'b00);
      step(1);
      reset_n = 1'b1;
      for (int i = 1; i <= 12; i++) begin
         step(1);
         chk($sformatf("coin_held_after_rst_%0d", i), coin_a, 2'b00);
      end
      joy_a[25] = 1'b0;
      step(3);

      af_a = 4'b0001;
      joy_a[4] = 1'b1;
      joy_a[5] = 1'b1;
      for (int i = 1; i <= 16; i++) begin
         step(1);
         chk($sformatf("af_btn0_%0d", i), btn_a[0], (((cyc - 1) / 4) % 2 == 0) ? 1'b1 : 1'b0);
         chk($sformatf("af_btn1_%0d", i), btn_a[1], 1'b1);
      end
      joy_a[5:4] = 2'b00;
      af_a = 4'b0000;
      step(2); chk("af_off", btn_a, 8'h00);

      dipw(8'd254, 25'd3, 8'hA5);
      chk("dip_a_bank3", dip_a, 64'h3C3C3C3CA53C3C3C);
      chk("dip_b_bank3_ignored", dip_b, 16'h0000);
      dipw(8'd254, 25'd8, 8'h11);
      chk("dip_addr8", dip_a, 64'h3C3C3C3CA53C3C3C);
      dipw(8'd253, 25'd1, 8'h22);
      chk("dip_idx253", dip_a, 64'h3C3C3C3CA53C3C3C);
      dipw(8'd254, 25'd1, 8'h5A);
      chk("dip_a_bank1", dip_a, 64'h3C3C3C3CA53C5A3C);
      chk("dip_b_bank1", dip_b, 16'h5A00);

      key(1'b0, 1'b1, 8'h76);
      for (int i = 1; i <= 12; i++) begin
         step(1);
         chk($sformatf("b_coin76_%0d", i), coin_b, (i >= 3 && i <= 10) ? 1'b1 : 1'b0);
         chk($sformatf("a_coin76_%0d", i), coin_a, (i >= 3 && i <= 10) ? 2'b01 : 2'b00);
      end
      key(1'b0, 1'b0, 8'h76);
      step(3);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
